mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (requester A) and data load/store (requester B) in the multi-cycle MIPS core.
- A registered select drives the mux2 instances that steer address, write data and write enable onto the memory port.
- Round-robin arbitration, variable memory latency via a ready handshake, and a per-transaction timeout counter.

Parameters:
- ADDR_WIDTH, 32, address width of requesters and memory port.
- DATA_WIDTH, 32, data width of the write and read paths.
- TIMEOUT, 16, maximum BUSY cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  requester A wants a transaction; held with payload until a_done.
- a_addr  in  ADDR_WIDTH  requester A address.
- a_we  in  1  requester A write enable.
- a_wdata  in  DATA_WIDTH  requester A write data.
- a_done  out  1  one-cycle completion pulse to A.
- a_err  out  1  one-cycle timeout pulse to A, coincident with a_done.
- b_req, b_addr, b_we, b_wdata, b_done, b_err: same as A, for requester B.
- mem_req  out  1  transaction active on the memory port.
- mem_addr  out  ADDR_WIDTH  muxed address.
- mem_we  out  1  muxed write enable, gated by mem_req.
- mem_wdata  out  DATA_WIDTH  muxed write data.
- mem_ready  in  1  memory completes the current transaction this cycle.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready=1.
- rdata  out  DATA_WIDTH  mem_rdata passthrough; meaningful only on a_done or b_done.
- sel  out  1  registered mux select: 0=A, 1=B.
- busy  out  1  high in either BUSY state.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, sel=0, last_grant=B (so A wins the first tie), cnt=0. mem_req, a_done, b_done, a_err, b_err and busy are all 0.
- States: IDLE, BUSY_A, BUSY_B.
- IDLE, both requests high: grant the requester not equal to last_grant.
- IDLE, one request high: grant that requester.
- IDLE, no request: remain in IDLE.
- On a grant: next state is BUSY_x, sel<=x, last_grant<=x, cnt<=0. sel changes only on this IDLE->BUSY edge.
- BUSY_x outputs: mem_req=1, busy=1. mem_addr, mem_wdata and mem_we come from requester x via the mux on sel; mem_we is forced 0 outside BUSY.
- BUSY_x with mem_ready=1: x_done=1 that cycle, rdata=mem_rdata, next state IDLE.
- BUSY_x with mem_ready=0: cnt<=cnt+1.
- Timeout: if TIMEOUT!=0 and cnt==TIMEOUT-1 with mem_ready=0, then x_done=1 and x_err=1, next state IDLE.
- mem_ready and timeout in the same cycle: ready wins; no error.
- Latency: request seen in IDLE at cycle N -> mem_req at N+1. Minimum done at N+1 (mem_ready already high).
- Turnaround: at least one IDLE cycle between transactions. Back-to-back requests from both sides alternate A,B,A,B.
- mem_ready while IDLE: ignored; no done pulse.
- x_req dropped during BUSY_x: protocol violation. The transaction still completes or times out normally.
- Reset mid-BUSY: IDLE on the next edge, mem_req drops, no done or err pulse for the killed transaction.
- Counter width: max(1, clog2(TIMEOUT+1)). The counter does not increment while IDLE.

Decomposition:
- Package mem_arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_BUSY_A=2'd1, ST_BUSY_B=2'd2;
  - SEL_A=1'b0, SEL_B=1'b1, matching the mux2 choose encoding.
- Sub-module: three instances of the existing mux2, for address (ADDR_WIDTH), write data (DATA_WIDTH) and write enable (width 1), all driven by sel. No new sub-module.

Test Plan:
- Single A read, mem_ready at 3rd BUSY cycle, addr=0x0040_0000 -> mem_req high 3 cycles, mem_addr=0x0040_0000, a_done pulse with rdata=mem_rdata=0xDEADBEEF, b_done=0.
- a_req and b_req both held after reset, mem_ready always 1 -> grants A,B,A,B; each done one cycle after its grant; one IDLE cycle between transactions.
- B write, b_we=1, b_wdata=0x1234_5678 -> sel=1, mem_we=1 only during BUSY_B, mem_wdata=0x1234_5678, b_done pulse.
- TIMEOUT=4, mem_ready never asserted -> exactly 4 BUSY cycles, then a_done=a_err=1 for one cycle, then IDLE.
- TIMEOUT=4, mem_ready asserted exactly on the 4th BUSY cycle -> a_done=1, a_err=0.
- reset asserted in the 2nd BUSY_B cycle -> next cycle mem_req=0, busy=0, no b_done. The next tie grants A.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory-port arbiter.
// State codes and mux select values used by mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_A = 2'd1,
    ST_BUSY_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2.sv
// Generic two-input mux; s=0 picks d0, s=1 picks d1.
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (A) and
// load/store (B), with ready handshake and per-transaction timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic                  a_we,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_done,
  output logic                  a_err,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  b_we,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_done,
  output logic                  b_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sel,
  output logic                  busy
);

  localparam int CW   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TLIM);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_b;
  logic          tmo;
  logic          fin;
  logic          we_mux;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_A;
      last_q  <= SEL_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_b = 1'b0;
    tmo     = 1'b0;
    fin     = 1'b0;
    mem_req = 1'b0;
    busy    = 1'b0;
    a_done  = 1'b0;
    a_err   = 1'b0;
    b_done  = 1'b0;
    b_err   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // On a tie, B wins only if A was served last
        grant_b = b_req & (~a_req | (last_q == SEL_A));
        if (a_req | b_req) begin
          state_d = grant_b ? ST_BUSY_B : ST_BUSY_A;
          sel_d   = grant_b ? SEL_B : SEL_A;
          last_d  = grant_b ? SEL_B : SEL_A;
          cnt_d   = '0;
        end
      end
      ST_BUSY_A, ST_BUSY_B: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        tmo     = TO_EN & ~mem_ready & (cnt_q == CNT_LAST);
        fin     = mem_ready | tmo;
        if (fin) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        // A transaction killed by reset reports nothing
        a_done = fin & ~reset & (state_q == ST_BUSY_A);
        b_done = fin & ~reset & (state_q == ST_BUSY_B);
        a_err  = tmo & ~reset & (state_q == ST_BUSY_A);
        b_err  = tmo & ~reset & (state_q == ST_BUSY_B);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mux2 #(.W(ADDR_WIDTH)) u_mux_addr (
    .d0_i (a_addr),
    .d1_i (b_addr),
    .sel_i(sel_q),
    .y_o  (mem_addr)
  );

  mux2 #(.W(DATA_WIDTH)) u_mux_wdata (
    .d0_i (a_wdata),
    .d1_i (b_wdata),
    .sel_i(sel_q),
    .y_o  (mem_wdata)
  );

  mux2 #(.W(1)) u_mux_we (
    .d0_i (a_we),
    .d1_i (b_we),
    .sel_i(sel_q),
    .y_o  (we_mux)
  );

  assign mem_we = we_mux & mem_req;
  assign rdata  = mem_rdata;
  assign sel    = sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random bench for mem_port_arbiter with transaction-level model
// and a done-pulse scoreboard.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, b_req;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_we, b_we;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_done, a_err, b_done, b_err;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;
  logic          sel, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_we     (a_we),
    .a_wdata  (a_wdata),
    .a_done   (a_done),
    .a_err    (a_err),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_we     (b_we),
    .b_wdata  (b_wdata),
    .b_done   (b_done),
    .b_err    (b_err),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .rdata    (rdata),
    .sel      (sel),
    .busy     (busy)
  );

  typedef struct {
    int          who;
    bit          err;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   running = 1'b1;
  int   ngrant[2];
  int   ntmo = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: any done/err pulse must match the oldest expected completion
  initial begin
    exp_t e;
    logic [1:0] wmask;
    while (running) begin
      @(negedge clk);
      if (a_done === 1'b1 || b_done === 1'b1 ||
          a_err === 1'b1 || b_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {a_done, b_done, a_err, b_err}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          wmask = (e.who == 0) ? 2'b10 : 2'b01;
          chk("done_who", {a_done, b_done}, wmask);
          chk("err_bits", {a_err, b_err}, e.err ? wmask : 2'b00);
          if (!e.err) chk("rdata", rdata, e.rd);
        end
      end
    end
  end

  // Transaction-level reference: who owns the port and for how long
  int          owner;
  int          waited;
  int          last;
  int          msel;
  int          fin_who;
  bit          pend[2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wdata[2];
  bit          p_we[2];
  bit          stall_phase;

  initial begin
    owner = -1; waited = 0; last = 1; msel = 0;
    pend[0] = 0; pend[1] = 0;
    ngrant[0] = 0; ngrant[1] = 0;
    stall_phase = 0;
    reset = 1'b1;
    a_req = 0; b_req = 0; a_addr = '0; b_addr = '0;
    a_we = 0; b_we = 0; a_wdata = '0; b_wdata = '0;
    mem_ready = 0; mem_rdata = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      fin_who = -1;
      if (reset) begin
        owner = -1; waited = 0; last = 1; msel = 0;
      end else if (owner < 0) begin
        if (a_req && b_req) owner = 1 - last;
        else if (a_req) owner = 0;
        else if (b_req) owner = 1;
        if (owner >= 0) begin
          last = owner; msel = owner; waited = 0;
          ngrant[owner]++;
        end
      end else if (mem_ready || waited + 1 >= TO) begin
        fin_who = owner;
        owner = -1;
      end else begin
        waited++;
      end
      #1;
      chk("mem_req", mem_req, owner >= 0);
      chk("busy", busy, owner >= 0);
      chk("sel", sel, msel[0]);
      if (owner >= 0) begin
        chk("mem_addr", mem_addr, p_addr[owner]);
        chk("mem_wdata", mem_wdata, p_wdata[owner]);
        chk("mem_we", mem_we, p_we[owner]);
      end else begin
        chk("mem_we_idle", mem_we, 1'b0);
      end

      if (reset) begin
        pend[0] = 0; pend[1] = 0;
      end
      if (fin_who >= 0) pend[fin_who] = 0;

      reset = (cyc < 3) || ($urandom_range(0, 249) == 0);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r]    = 1;
          p_addr[r]  = $urandom;
          p_wdata[r] = $urandom;
          p_we[r]    = $urandom_range(0, 1) == 1;
        end
      end
      a_req = pend[0]; a_addr = p_addr[0];
      a_we = p_we[0]; a_wdata = p_wdata[0];
      b_req = pend[1]; b_addr = p_addr[1];
      b_we = p_we[1]; b_wdata = p_wdata[1];

      if ($urandom_range(0, 39) == 0) stall_phase = ~stall_phase;
      mem_ready = stall_phase ? 1'b0 : ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;

      if (!reset && owner >= 0 &&
          (mem_ready || waited + 1 >= TO)) begin
        exp_q.push_back('{who: owner, err: !mem_ready,
                          rd: mem_rdata});
        if (!mem_ready) ntmo++;
      end
    end

    a_req = 0; b_req = 0; reset = 0;
    repeat (TO + 3) @(posedge clk);
    @(negedge clk);
    running = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("saw_grants", (ngrant[0] > 10) && (ngrant[1] > 10), 1'b1);
    chk("saw_timeouts", ntmo > 2, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
